aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Sequencer for the single-round AES-128 key expansion datapath.
- Accepts a cipher key and drives that datapath's round index, per-round byte counter and initial key.
- Captures each newly generated round key and delivers all 11 round keys (idx 0..10), in order, to the cipher round datapath over a valid/ready handshake.
- Sits between the top-level AES control and the key expansion unit.

Parameters:
- NR, 10, number of cipher rounds; total keys delivered is NR+1.
- CNT_LAST, 7, final value of the per-round byte counter; datapath commits a round key on this cycle.
- KEY_W, 128, key and round-key width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a key schedule; sampled only in IDLE
- key_reuse  in  1  replay cached schedule (only used with the optional feature)
- key_in  in  KEY_W  cipher key, sampled on accepted start
- ke_key  out  KEY_W  key to expansion datapath (registered copy of key_in)
- ke_round  out  4  round index to expansion datapath
- ke_cnt  out  3  byte-step counter to expansion datapath
- ke_round_key  in  KEY_W  current round key from expansion datapath
- rk_valid  out  1  round key available
- rk_ready  in  1  consumer accepts round key
- rk_data  out  KEY_W  round key, registered
- rk_idx  out  4  round-key index 0..NR
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after idx NR is accepted

Behaviour:
- Reset: state IDLE; all outputs 0 (ke_key, ke_round, ke_cnt, rk_valid, rk_data, rk_idx, busy, done).
- States: IDLE, LOAD, HOLD, EXPAND, CAPTURE.
- IDLE:
  - start=1 → latch key_in into ke_key; set ke_round=0; go to LOAD.
  - start in any other state is ignored (no queueing).
- LOAD (1 cycle):
  - ke_round=0, so the datapath loads ke_key.
  - rk_data<=ke_key, rk_idx<=0; go to HOLD.
- HOLD:
  - rk_valid=1; rk_data/rk_idx stable until handshake (rk_valid & rk_ready).
  - ke_cnt=0; ke_round unchanged.
  - Handshake with rk_idx<NR → ke_round<=rk_idx+1, ke_cnt<=0, go to EXPAND.
  - Handshake with rk_idx==NR → done pulse next cycle, go to IDLE; ke_round keeps its final value.
- EXPAND:
  - ke_cnt increments 0..CNT_LAST, one per cycle, CNT_LAST+1 cycles total.
  - At ke_cnt==CNT_LAST, go to CAPTURE; ke_cnt returns to 0.
- CAPTURE (1 cycle):
  - rk_data<=ke_round_key, rk_idx<=ke_round; go to HOLD.
- Latency:
  - start accepted at cycle T → first rk_valid at T+2.
  - Handshake at cycle h → next rk_valid at h+10 (defaults).
  - With rk_ready tied high, idx NR is valid at T+102 and done pulses at T+103.
- Backpressure: rk_ready low holds HOLD indefinitely; ke_cnt stays 0, so the datapath state is frozen.
- rk_ready with rk_valid low: no effect.
- rst_n asserted mid-schedule: immediate return to IDLE with reset values; the interrupted schedule is discarded.
- ke_round width: 4 bits, range 0..NR; NR must be ≤15.

Optional Feature:
- Macro: AES_KS_CACHE_EN.
- With the macro:
  - An internal (NR+1)×KEY_W array stores every round key as it is captured.
  - A cache_valid flag is set when idx NR is captured; it is cleared by reset and by any start with key_reuse=0.
  - start with key_reuse=1 and cache_valid=1 → skip LOAD/EXPAND/CAPTURE; go IDLE→HOLD in 1 cycle.
  - Replay delivers cached keys idx 0..NR; each subsequent key is valid 1 cycle after the prior handshake.
  - ke_* outputs are unchanged during replay.
  - key_reuse=1 with cache_valid=0 behaves as a normal start.
- Without the macro: key_reuse is ignored and there is no storage.

Decomposition:
- Shared package aes_pkg holds:
  - KEY_W, NR, CNT_LAST constants.
  - State enum type for IDLE/LOAD/HOLD/EXPAND/CAPTURE.
  - FIPS-197 test key constants for benches.
- One natural sub-module, aes_rk_cache: the round-key array with write port (capture) and read port (idx). It is instantiated only under AES_KS_CACHE_EN.

Test Plan:
- Vector notation: 128-bit values are written with w0 in bits [31:0] and w3 in [127:96].
- Reset then start with key {09cf4f3c,abf71588,28aed2a6,2b7e1516}, rk_ready=1 → rk_idx 0 equals the key at T+2; idx1 = {2a6c7605,23a33939,88542cb1,a0fafe17}; idx10 = {b6630ca6,e13f0cc8,c9ee2589,d014f9a8} at T+102; done pulses at T+103.
- Same key, rk_ready low 20 cycles in HOLD at idx 3 → rk_data/rk_idx stable and ke_cnt=0 throughout; the remaining keys match the previous run.
- start pulsed during EXPAND → ignored; sequence and key values unchanged.
- rst_n asserted at idx 5 EXPAND cnt=4 → all outputs 0 next sample; a fresh start yields a correct idx 0..10 sequence.
- ke_cnt trace per round, checked against a cycle counter → exactly 0,1,..,7 then CAPTURE; ke_round steps 1..10.
- AES_KS_CACHE_EN: after a full run, start with key_reuse=1 and rk_ready=1 → idx 0 at T+1, then one key per cycle, identical to the first run; ke_round/ke_cnt unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM state type and FIPS-197 test vectors for the AES-128 key schedule sequencer.
// Contents:
//    KEY_W, NR, CNT_LAST  key width, cipher rounds, last byte-step count
//    ks_state_e           sequencer states
//    AES_TEST_*           FIPS-197 appendix A.1 key and selected round keys (w0 in [31:0])
package aes_pkg;
   localparam int KEY_W    = 128;
   localparam int NR       = 10;
   localparam int CNT_LAST = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HOLD,
      ST_EXPAND,
      ST_CAPTURE
   } ks_state_e;

   localparam logic [KEY_W-1:0] AES_TEST_KEY  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
   localparam logic [KEY_W-1:0] AES_TEST_RK1  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
   localparam logic [KEY_W-1:0] AES_TEST_RK10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
endpackage

// File: rtl/aes_rk_cache.sv
// aes_rk_cache: NR+1 entry round-key store, written as keys are captured and read by round index for replay.
// Ports:
//    clk      clock
//    wr_en    write strobe
//    wr_idx   round index to write
//    wr_data  round key to store
//    rd_idx   round index to read (combinational)
//    rd_data  stored round key
module aes_rk_cache
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             wr_en,
   input  logic [3:0]       wr_idx,
   input  logic [KEY_W-1:0] wr_data,
   input  logic [3:0]       rd_idx,
   output logic [KEY_W-1:0] rd_data
);
   logic [KEY_W-1:0] mem [0:NR];

   always_ff @(posedge clk)
      if (wr_en) mem[wr_idx] <= wr_data;

   assign rd_data = mem[rd_idx];
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequences the single-round AES-128 key expansion datapath and delivers round keys 0..NR over valid/ready.
// Ports:
//    clk, rst_n     clock, asynchronous active-low reset
//    start          begin a schedule (sampled in IDLE only)
//    key_reuse      replay the cached schedule (AES_KS_CACHE_EN builds only)
//    key_in         cipher key, captured on an accepted start
//    ke_key         registered key to the expansion datapath
//    ke_round       round index to the expansion datapath
//    ke_cnt         byte-step counter to the expansion datapath
//    ke_round_key   current round key from the expansion datapath
//    rk_valid       round key available
//    rk_ready       consumer accepts round key
//    rk_data        registered round key
//    rk_idx         round-key index 0..NR
//    busy           high outside IDLE
//    done           one-cycle pulse after idx NR is accepted
// Build option: define AES_KS_CACHE_EN to keep every round key and allow replay without re-expansion.
module aes_key_sched_ctrl
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             key_reuse,
   input  logic [KEY_W-1:0] key_in,
   output logic [KEY_W-1:0] ke_key,
   output logic [3:0]       ke_round,
   output logic [2:0]       ke_cnt,
   input  logic [KEY_W-1:0] ke_round_key,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic [KEY_W-1:0] rk_data,
   output logic [3:0]       rk_idx,
   output logic             busy,
   output logic             done
);
   localparam logic [3:0] LAST_IDX = 4'(NR);
   localparam logic [2:0] CNT_END  = 3'(CNT_LAST);

   ks_state_e        state, state_nx;
   logic             hs, last, replay, replay_go;
   logic [KEY_W-1:0] cache_rd;

   assign hs   = rk_valid & rk_ready;
   assign last = rk_idx == LAST_IDX;

`ifdef AES_KS_CACHE_EN
   logic       cache_valid;
   logic [3:0] cache_rd_idx;

   assign replay_go = key_reuse & cache_valid;
   // IDLE reads entry 0 for the first replayed key; HOLD prefetches the next one
   assign cache_rd_idx = (state == ST_IDLE) ? 4'd0 : rk_idx + 4'd1;

   aes_rk_cache u_cache (
      .clk     (clk),
      .wr_en   (state == ST_LOAD || state == ST_CAPTURE),
      .wr_idx  ((state == ST_LOAD) ? 4'd0 : ke_round),
      .wr_data ((state == ST_LOAD) ? ke_key : ke_round_key),
      .rd_idx  (cache_rd_idx),
      .rd_data (cache_rd)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cache_valid <= 1'b0;
         replay      <= 1'b0;
      end else begin
         if (state == ST_IDLE && start) begin
            replay <= replay_go;
            if (!key_reuse) cache_valid <= 1'b0;
         end
         if (state == ST_CAPTURE && ke_round == LAST_IDX) cache_valid <= 1'b1;
      end
`else
   logic unused_key_reuse;

   assign unused_key_reuse = key_reuse;
   assign replay_go        = 1'b0;
   assign replay           = 1'b0;
   assign cache_rd         = '0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      rk_valid = state == ST_HOLD;
      busy     = state != ST_IDLE;
      case (state)
         ST_IDLE:    state_nx = start ? (replay_go ? ST_HOLD : ST_LOAD) : ST_IDLE;
         ST_LOAD:    state_nx = ST_HOLD;
         ST_HOLD:    state_nx = hs ? (last ? ST_IDLE : (replay ? ST_HOLD : ST_EXPAND)) : ST_HOLD;
         ST_EXPAND:  state_nx = (ke_cnt == CNT_END) ? ST_CAPTURE : ST_EXPAND;
         ST_CAPTURE: state_nx = ST_HOLD;
         default:    state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ke_key   <= '0;
         ke_round <= '0;
         ke_cnt   <= '0;
         rk_data  <= '0;
         rk_idx   <= '0;
         done     <= 1'b0;
      end else begin
         done <= hs & last;
         case (state)
            ST_IDLE:
               if (start && replay_go) begin
                  rk_data <= cache_rd;
                  rk_idx  <= '0;
               end else if (start) begin
                  ke_key   <= key_in;
                  ke_round <= '0;
               end
            ST_LOAD: begin
               rk_data <= ke_key;
               rk_idx  <= '0;
            end
            ST_HOLD:
               // replay stays in HOLD and steps through the cache; ke_* stay frozen
               if (hs && !last && replay) begin
                  rk_data <= cache_rd;
                  rk_idx  <= rk_idx + 4'd1;
               end else if (hs && !last) begin
                  ke_round <= rk_idx + 4'd1;
                  ke_cnt   <= '0;
               end
            ST_EXPAND: ke_cnt <= (ke_cnt == CNT_END) ? 3'd0 : ke_cnt + 3'd1;
            ST_CAPTURE: begin
               rk_data <= ke_round_key;
               rk_idx  <= ke_round;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed + randomized bench with an FIPS-197 key expansion reference and a behavioural expansion datapath.
module tb_aes_key_sched_ctrl;
   import aes_pkg::*;

   logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, key_reuse = 1'b0, rk_ready = 1'b0;
   logic [KEY_W-1:0] key_in = '0, ke_key, ke_round_key, rk_data;
   logic [3:0]       ke_round, rk_idx;
   logic [2:0]       ke_cnt;
   logic             rk_valid, busy, done;

   logic [7:0]       sb [0:255];
   logic [KEY_W-1:0] ref_rk [0:NR];
   logic [KEY_W-1:0] dp = '0;
   int               n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   aes_key_sched_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .key_reuse    (key_reuse),
      .key_in       (key_in),
      .ke_key       (ke_key),
      .ke_round     (ke_round),
      .ke_cnt       (ke_cnt),
      .ke_round_key (ke_round_key),
      .rk_valid     (rk_valid),
      .rk_ready     (rk_ready),
      .rk_data      (rk_data),
      .rk_idx       (rk_idx),
      .busy         (busy),
      .done         (done)
   );

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   // behavioural expansion unit: one full round key per commit, keyed by the round number
   function automatic logic [KEY_W-1:0] nxt(input logic [KEY_W-1:0] p, input logic [3:0] r);
      logic [7:0]  rc;
      logic [31:0] a, b, c, d;
      rc = 8'h01;
      for (int i = 1; i < int'(r); i++) rc = xt(rc);
      a = p[31:0] ^ subw({p[119:96], p[127:120]}) ^ {rc, 24'h0};
      b = p[63:32] ^ a;
      c = p[95:64] ^ b;
      d = p[127:96] ^ c;
      return {d, c, b, a};
   endfunction

   always @(posedge clk)
      if (ke_cnt == 3'd7)        dp <= nxt(dp, ke_round);
      else if (ke_round == 4'd0) dp <= ke_key;

   assign ke_round_key = dp;

   // FIPS-197 KeyExpansion over the 44-word list
   task automatic build_ref(input logic [KEY_W-1:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= NR; r++) ref_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
   endtask

   task automatic chk(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ke_key"}, ke_key, 0);
      chk({tag, "_ke_round"}, ke_round, 0);
      chk({tag, "_ke_cnt"}, ke_cnt, 0);
      chk({tag, "_rk_valid"}, rk_valid, 0);
      chk({tag, "_rk_data"}, rk_data, 0);
      chk({tag, "_rk_idx"}, rk_idx, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: order/data only, 1: default latency rules, 2: replay latency rules
   task automatic run(input logic [KEY_W-1:0] key, input bit reuse, input int mode,
                      input bit stall, input bit rnd, input int glitch_k, input int abort_k);
      int         k, p, exp_idx, stall_left;
      bit         fin_pend, fin;
      logic [3:0] rnd0;
      logic [KEY_W-1:0] kk0;
      build_ref(key);
      rnd0      = ke_round;
      kk0       = ke_key;
      key_in    = (mode == 2) ? ~key : key;
      key_reuse = reuse;
      start     = 1'b1;
      tick();
      start      = 1'b0;
      key_reuse  = 1'b0;
      exp_idx    = 0;
      stall_left = -1;
      fin_pend   = 1'b0;
      fin        = 1'b0;
      for (k = 1; k < 800 && !fin; k++) begin
         chk("done", done, fin_pend);
         if (fin_pend) begin
            chk("end_busy", busy, 0);
            if (mode == 1) chk("done_time", k, 103);
            if (mode == 2) chk("done_time_r", k, 12);
            fin = 1'b1;
         end else begin
            if (mode == 1) begin
               p = k - 2;
               chk("valid_t", rk_valid, p >= 0 && p % 10 == 0 && p <= 100);
               if (p > 0 && p < 100 && p % 10 >= 1 && p % 10 <= 8) begin
                  chk("cnt_t", ke_cnt, p % 10 - 1);
                  chk("round_t", ke_round, p / 10 + 1);
               end
               if (p > 0 && p < 100 && p % 10 == 9) chk("cnt_cap", ke_cnt, 0);
            end
            if (mode == 2) begin
               chk("valid_r", rk_valid, k <= 11);
               chk("round_r", ke_round, rnd0);
               chk("cnt_r", ke_cnt, 0);
               chk("key_r", ke_key, kk0);
            end
            if (k == abort_k) begin
               rst_n = 1'b0;
               #1;
               chk_zero("abort");
               tick();
               rst_n = 1'b1;
               return;
            end
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall && rk_valid && rk_idx == 4'd3 && stall_left < 0) stall_left = 20;
            if (stall_left > 0) begin
               rk_ready = 1'b0;
               stall_left--;
            end
            if (rk_valid) begin
               chk("rk_idx", rk_idx, exp_idx);
               chk("rk_data", rk_data, ref_rk[exp_idx]);
               chk("hold_cnt", ke_cnt, 0);
               if (key == AES_TEST_KEY && exp_idx == 1) chk("fips_rk1", rk_data, AES_TEST_RK1);
               if (key == AES_TEST_KEY && exp_idx == NR) chk("fips_rk10", rk_data, AES_TEST_RK10);
               if (rk_ready) begin
                  exp_idx++;
                  if (exp_idx == NR + 1) fin_pend = 1'b1;
               end
            end
            start = (k == glitch_k);
            tick();
         end
      end
      start = 1'b0;
      chk("n_keys", exp_idx, NR + 1);
      chk("finished", fin, 1);
   endtask

   initial begin
      logic [7:0]       v;
      logic [KEY_W-1:0] rk;
      for (int x = 0; x < 256; x++) begin
         v = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
         sb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      end
      repeat (3) tick();
      chk_zero("reset");
      rst_n = 1'b1;
      tick();
      run(AES_TEST_KEY, 1'b1, 1, 1'b0, 1'b0, -1, -1);
      run(AES_TEST_KEY, 1'b0, 0, 1'b1, 1'b0, -1, -1);
      run(AES_TEST_KEY, 1'b0, 1, 1'b0, 1'b0, 35, -1);
      rk = {$urandom, $urandom, $urandom, $urandom};
      run(rk, 1'b0, 1, 1'b0, 1'b0, -1, 47);
      run(rk, 1'b0, 1, 1'b0, 1'b0, -1, -1);
      rk = {$urandom, $urandom, $urandom, $urandom};
      run(rk, 1'b0, 0, 1'b0, 1'b1, -1, -1);
`ifdef AES_KS_CACHE_EN
      run(rk, 1'b1, 2, 1'b0, 1'b0, -1, -1);
      rk = {$urandom, $urandom, $urandom, $urandom};
      run(rk, 1'b0, 1, 1'b0, 1'b0, -1, -1);
`endif
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
